led_pattern_gen: RTL and testbench

Parametrised test-pattern source for the LED matrix pipeline. It generates full frames of packed RGB pixels in row-major order over a valid/ready stream. A sync pulse accompanies the first pixel of each frame, and the stream drives the led_matrix_top pixel input directly. Compared with a fixed bring-up counter, it adds selectable pattern modes, backpressure, single-shot or continuous frames, an inter-frame gap and a frame counter.

---
 rtl/led_pattern_gen_if.sv | 24 ++
 rtl/led_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Pixel stream bundle: valid/ready beat carrying packed {R,G,B} and a frame sync.
// master drives valid/sync/rgb and samples ready; slave is the downstream sink.
interface led_pattern_gen_if #(
  parameter int COLOR_DEPTH = 4
);
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     pix_sync;
  logic [3*COLOR_DEPTH-1:0] pix_rgb;

  modport master (
    output pix_valid,
    output pix_sync,
    output pix_rgb,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_sync,
    input  pix_rgb,
    output pix_ready
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Test-pattern frame source: row-major RGB pixels on pix (master), sync on (0,0).
// Ports: clk, rst_n, i_start/i_abort/i_continuous/i_mode/i_solid_rgb, o_frame_done/o_frame_cnt/o_busy.
module led_pattern_gen #(
  parameter int PANEL_ROWS  = 64,
  parameter int PANEL_COLS  = 64,
  parameter int COLOR_DEPTH = 4,
  parameter int CHECK_LOG2  = 3,
  parameter int FRAME_GAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_continuous,
  input  logic [2:0]               i_mode,
  input  logic [3*COLOR_DEPTH-1:0] i_solid_rgb,
  led_pattern_gen_if.master        pix,
  output logic                     o_frame_done,
  output logic [15:0]              o_frame_cnt,
  output logic                     o_busy
);
  localparam int CD = COLOR_DEPTH;
  localparam int PW = 3 * CD;
  localparam int RW = $clog2(PANEL_ROWS);
  localparam int CW = $clog2(PANEL_COLS);
  localparam int IW = RW + CW;
  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(PANEL_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PANEL_COLS - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [PW-1:0] ONES = {PW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_nxt_state;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_nxt_row;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_nxt_col;
  logic [2:0]    r_mode;
  logic [2:0]    w_nxt_mode;
  logic [15:0]   r_fcnt;
  logic [15:0]   w_nxt_fcnt;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_nxt_gap;
  logic          r_valid;
  logic          r_sync;
  logic          r_done;
  logic          r_busy;
  logic [PW-1:0] r_rgb;
  logic [PW-1:0] w_rgb;

  logic          w_xfer;
  logic          w_last;
  logic          w_done;
  logic          w_run;
  logic          w_fstart;
  logic          w_hold;
  logic [2:0]    w_bar;
  logic          w_chk;
  logic          w_edge;
  logic          w_hit;

  assign w_xfer = r_valid & pix.pix_ready;
  assign w_last = w_xfer && (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_done = w_last & ~i_abort;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt_state;
  end

  // next-state logic; abort beats every other transition
  always_comb begin
    w_nxt_state = r_state;
    if (i_abort) begin
      w_nxt_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (i_start) w_nxt_state = S_RUN;
        S_RUN: begin
          if (w_last) begin
            if (!i_continuous)      w_nxt_state = S_IDLE;
            else if (FRAME_GAP > 0) w_nxt_state = S_GAP;
            else                    w_nxt_state = S_RUN;
          end
        end
        S_GAP: if (r_gap == GAP_LAST) w_nxt_state = S_RUN;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // next pixel position, frame bookkeeping and pattern
  always_comb begin
    w_run      = (w_nxt_state == S_RUN);
    w_fstart   = w_run && ((r_state != S_RUN) || w_last);
    w_nxt_mode = w_fstart ? i_mode : r_mode;
    w_hold     = r_valid && !pix.pix_ready && w_run;
    w_nxt_row  = r_row;
    w_nxt_col  = r_col;
    if (i_abort || w_last) begin
      w_nxt_row = '0;
      w_nxt_col = '0;
    end else if (w_xfer) begin
      w_nxt_col = r_col + 1'b1;
      if (r_col == COL_LAST) w_nxt_row = r_row + 1'b1;
    end
    w_nxt_fcnt = r_fcnt + {15'd0, w_done};
    w_nxt_gap  = '0;
    if ((r_state == S_GAP) && (w_nxt_state == S_GAP))
      w_nxt_gap = r_gap + 1'b1;
  end

  // pattern is computed for the pixel presented next cycle,
  // so a new frame's pixel (0,0) sees the already-bumped frame count
  assign w_bar  = w_nxt_col[CW-1 -: 3];
  assign w_chk  = w_nxt_row[CHECK_LOG2] ^ w_nxt_col[CHECK_LOG2];
  assign w_edge = (w_nxt_row == '0) || (w_nxt_row == ROW_LAST) ||
                  (w_nxt_col == '0) || (w_nxt_col == COL_LAST);
  assign w_hit  = ({w_nxt_row, w_nxt_col} == IW'(w_nxt_fcnt));

  always_comb begin
    w_rgb = '0;
    unique case (1'b1)
      (w_nxt_mode == 3'd0): w_rgb = i_solid_rgb;
      (w_nxt_mode == 3'd1): w_rgb = {w_nxt_row[RW-1 -: CD],
                                     w_nxt_col[CW-1 -: CD],
                                     w_nxt_fcnt[CD-1:0]};
      (w_nxt_mode == 3'd2): w_rgb = w_chk ? ONES : '0;
      (w_nxt_mode == 3'd3): w_rgb = {{CD{w_bar[2]}},
                                     {CD{w_bar[1]}},
                                     {CD{w_bar[0]}}};
      (w_nxt_mode == 3'd4): w_rgb = w_edge ? ONES : '0;
      (w_nxt_mode == 3'd5): w_rgb = w_hit ? ONES : '0;
      default:              w_rgb = '0;
    endcase
  end

  // registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_mode  <= '0;
      r_fcnt  <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
      r_sync  <= 1'b0;
      r_rgb   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_row   <= w_nxt_row;
      r_col   <= w_nxt_col;
      r_mode  <= w_nxt_mode;
      r_fcnt  <= w_nxt_fcnt;
      r_gap   <= w_nxt_gap;
      r_valid <= w_run;
      r_done  <= w_done;
      r_busy  <= (w_nxt_state != S_IDLE);
      // a stalled beat keeps its payload even if solid_rgb moves
      if (!w_hold) begin
        r_sync <= w_run && (w_nxt_row == '0) && (w_nxt_col == '0);
        r_rgb  <= w_run ? w_rgb : '0;
      end
    end
  end

  assign pix.pix_valid = r_valid;
  assign pix.pix_sync  = r_sync;
  assign pix.pix_rgb   = r_rgb;
  assign o_frame_done  = r_done;
  assign o_frame_cnt   = r_fcnt;
  assign o_busy        = r_busy;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen with a frame-level pixel reference model.
// Second instance (no inter-frame gap) checks back-to-back continuous frames.
module tb_led_pattern_gen;
  localparam int ROWS = 64;
  localparam int COLS = 64;
  localparam int CD   = 4;
  localparam int CL   = 3;
  localparam int NPIX = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, cont;
  logic [2:0]  mode;
  logic [11:0] solid;
  logic        done;
  logic [15:0] fcnt;
  logic        busy;

  logic        start0, abort0, cont0;
  logic [2:0]  mode0;
  logic        done0;
  logic [15:0] fcnt0;
  logic        busy0;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.COLOR_DEPTH(CD)) pif ();
  led_pattern_gen_if #(.COLOR_DEPTH(CD)) pif0 ();

  led_pattern_gen #(
    .PANEL_ROWS(ROWS), .PANEL_COLS(COLS), .COLOR_DEPTH(CD),
    .CHECK_LOG2(CL), .FRAME_GAP(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(start), .i_abort(abort),
    .i_continuous(cont), .i_mode(mode),
    .i_solid_rgb(solid), .pix(pif),
    .o_frame_done(done), .o_frame_cnt(fcnt),
    .o_busy(busy)
  );

  led_pattern_gen #(
    .PANEL_ROWS(ROWS), .PANEL_COLS(COLS), .COLOR_DEPTH(CD),
    .CHECK_LOG2(CL), .FRAME_GAP(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_start(start0), .i_abort(abort0),
    .i_continuous(cont0), .i_mode(mode0),
    .i_solid_rgb(solid), .pix(pif0),
    .o_frame_done(done0), .o_frame_cnt(fcnt0),
    .o_busy(busy0)
  );

  int n_chk = 0;
  int n_fail = 0;

  int beat = 0;
  int m_fcnt = 0;
  int m_mode = 0;
  bit exp_done = 1'b0;
  bit rdy_rand = 1'b0;
  bit prev_stall = 1'b0;
  logic [11:0] prev_rgb;
  logic        prev_sync;
  logic [11:0] cap [2][NPIX];
  int white_at [16];
  int gap_before [16];
  int idle_run = 0;
  int bad_pix = 0, bad_sync = 0, bad_stab = 0;
  int bad_done = 0, bad_cnt = 0;
  int beats0 = 0, bubble0 = 0, dones0 = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_pix(int md, int r, int c, int fc);
    logic [2:0] b;
    logic [3:0] rr, gg, bb;
    case (md)
      0: return solid;
      1: begin
        rr = 4'(r / (ROWS / 16));
        gg = 4'(c / (COLS / 16));
        bb = 4'(fc % 16);
        return {rr, gg, bb};
      end
      2: return (((r >> CL) + (c >> CL)) % 2 == 1) ? 12'hFFF : 12'h000;
      3: begin
        b = 3'(c / (COLS / 8));
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
      end
      4: return (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1)
                ? 12'hFFF : 12'h000;
      5: return (r * COLS + c == fc % NPIX) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  // called at every negedge: check outputs, drive ready, advance model
  task automatic observe(input bit no_rdy);
    logic rdy;
    if (done !== exp_done) bad_done++;
    if (fcnt !== 16'(m_fcnt)) bad_cnt++;
    exp_done = 1'b0;
    if (prev_stall && (pif.pix_rgb !== prev_rgb ||
                       pif.pix_sync !== prev_sync))
      bad_stab++;
    if (!pif.pix_valid) idle_run++;
    else begin
      if (idle_run > 0) gap_before[m_fcnt % 16] = idle_run;
      idle_run = 0;
    end
    rdy = no_rdy ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    pif.pix_ready = rdy;
    prev_stall = pif.pix_valid && !rdy;
    prev_rgb   = pif.pix_rgb;
    prev_sync  = pif.pix_sync;
    if (pif.pix_valid && rdy) begin
      cap[m_fcnt % 2][beat] = pif.pix_rgb;
      if (pif.pix_rgb !== ref_pix(m_mode, beat / COLS, beat % COLS, m_fcnt))
        bad_pix++;
      if (pif.pix_sync !== (beat == 0)) bad_sync++;
      if (pif.pix_rgb == 12'hFFF) white_at[m_fcnt % 16] = beat;
      beat++;
      if (beat == NPIX) begin
        beat = 0;
        exp_done = 1'b1;
        m_fcnt++;
        m_mode = int'(mode);
      end
    end
    if (busy0 && !pif0.pix_valid) bubble0++;
    if (pif0.pix_valid) beats0++;
    if (done0) dones0++;
  endtask

  task automatic report_bad(input string tag);
    check({tag, "_pix"},  bad_pix,  0);
    check({tag, "_sync"}, bad_sync, 0);
    check({tag, "_stab"}, bad_stab, 0);
    check({tag, "_done"}, bad_done, 0);
    check({tag, "_fcnt"}, bad_cnt,  0);
    bad_pix = 0; bad_sync = 0; bad_stab = 0;
    bad_done = 0; bad_cnt = 0;
  endtask

  task automatic do_start(input int md, input bit c);
    mode  = 3'(md);
    cont  = c;
    start = 1'b1;
    m_mode = md;
    @(negedge clk);
    start = 1'b0;
    check("lat_valid", pif.pix_valid, 1);
    check("lat_sync",  pif.pix_sync,  1);
    check("lat_rgb",   pif.pix_rgb,   ref_pix(md, 0, 0, m_fcnt));
    observe(1'b0);
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (m_fcnt < target && n < budget) begin
      @(negedge clk);
      observe(1'b0);
      n++;
    end
    check("frame_timeout", m_fcnt >= target, 1);
    @(negedge clk);
    observe(1'b0);
  endtask

  task automatic run_beats(input int target, input int budget);
    int n = 0;
    while (beat < target && n < budget) begin
      @(negedge clk);
      observe(1'b0);
      n++;
    end
    check("beat_timeout", beat >= target, 1);
  endtask

  initial begin
    int nrow;
    for (int i = 0; i < 16; i++) begin
      white_at[i]   = -1;
      gap_before[i] = -1;
    end
    rst_n = 1'b0;
    start = 0; abort = 0; cont = 0; mode = 0; solid = 12'h000;
    start0 = 0; abort0 = 0; cont0 = 0; mode0 = 3'd5;
    pif.pix_ready  = 1'b0;
    pif0.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", pif.pix_valid, 0);
    check("rst_sync",  pif.pix_sync,  0);
    check("rst_rgb",   pif.pix_rgb,   0);
    check("rst_done",  done, 0);
    check("rst_fcnt",  fcnt, 0);
    check("rst_busy",  busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    observe(1'b0);

    // continuous walking pixel, gap build and gapless build side by side
    rdy_rand = 1'b0;
    start0 = 1'b1;
    cont0  = 1'b1;
    do_start(5, 1'b1);
    start0 = 1'b0;
    run_until(2, 10000);
    cont  = 1'b0;
    cont0 = 1'b0;
    run_until(3, 6000);
    check("walk_f0", white_at[0], 0);
    check("walk_f1", white_at[1], 1);
    check("walk_f2", white_at[2], 2);
    check("gap_f1", gap_before[1], 4);
    check("gap_f2", gap_before[2], 4);
    check("cont_busy", busy, 0);
    check("nogap_bubble", bubble0, 0);
    check("nogap_beats", beats0, 3 * NPIX);
    check("nogap_dones", dones0, 3);
    check("nogap_fcnt", fcnt0, 3);
    check("nogap_busy", busy0, 0);
    report_bad("walk");

    // solid single frame
    solid = 12'hF00;
    do_start(0, 1'b0);
    run_until(4, 6000);
    check("solid_fcnt", fcnt, 4);
    check("solid_busy", busy, 0);
    check("solid_first", cap[1][0], 12'hF00);
    check("solid_last", cap[1][NPIX-1], 12'hF00);
    report_bad("solid");

    // colour bars
    do_start(3, 1'b0);
    run_until(5, 6000);
    check("bars_c0",  cap[0][0],  12'h000);
    check("bars_c7",  cap[0][7],  12'h000);
    check("bars_c8",  cap[0][8],  12'h00F);
    check("bars_c32", cap[0][32], 12'hF00);
    check("bars_c56", cap[0][56], 12'hFFF);
    nrow = 0;
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (cap[0][r * COLS + c] !== cap[0][c]) nrow++;
    check("bars_rows", nrow, 0);
    report_bad("bars");

    // checker under random backpressure
    rdy_rand = 1'b1;
    do_start(2, 1'b0);
    run_until(6, 20000);
    check("chk_p00", cap[1][0], 12'h000);
    check("chk_p80", cap[1][8 * COLS], 12'hFFF);
    report_bad("checker");

    // mode switch mid-frame; stray start mid-frame is ignored
    do_start(1, 1'b1);
    run_beats(100, 1000);
    mode  = 3'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    observe(1'b0);
    run_until(7, 20000);
    cont = 1'b0;
    run_until(8, 20000);
    check("grad_last", cap[0][NPIX-1], 12'hFF6);
    check("bord_p00", cap[1][0], 12'hFFF);
    check("bord_p11", cap[1][COLS + 1], 12'h000);
    check("bord_last", cap[1][NPIX-1], 12'hFFF);
    report_bad("modechg");

    // abort mid-frame, then abort beating start in IDLE
    do_start(4, 1'b0);
    run_beats(2000, 8000);
    abort = 1'b1;
    pif.pix_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", pif.pix_valid, 0);
    check("abort_sync",  pif.pix_sync, 0);
    check("abort_busy",  busy, 0);
    check("abort_done",  done, 0);
    check("abort_fcnt",  fcnt, 8);
    beat = 0;
    prev_stall = 1'b0;
    observe(1'b0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abst_valid", pif.pix_valid, 0);
    check("abst_busy",  busy, 0);
    observe(1'b0);
    rdy_rand = 1'b0;
    do_start(2, 1'b0);
    run_until(9, 6000);
    report_bad("abort");

    // asynchronous reset mid-frame
    rdy_rand = 1'b1;
    do_start(1, 1'b0);
    run_beats(300, 2000);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", pif.pix_valid, 0);
    check("mrst_sync",  pif.pix_sync, 0);
    check("mrst_rgb",   pif.pix_rgb, 0);
    check("mrst_busy",  busy, 0);
    check("mrst_fcnt",  fcnt, 0);
    check("mrst_done",  done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_fcnt = 0;
    beat = 0;
    exp_done = 1'b0;
    prev_stall = 1'b0;
    repeat (5) begin
      @(negedge clk);
      observe(1'b0);
    end
    check("post_rst_valid", pif.pix_valid, 0);
    report_bad("reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
